mem_cycle_ctrl: RTL and testbench
=================================

MEM_CYCLE_CTRL -- requirements
Module: mem_cycle_ctrl

Interface
REQ-001 SHALL have parameter ROM_WAIT, default 1, wait-state count for ROM cycles (0..15).
REQ-002 SHALL have parameter RAM_WAIT, default 0, wait-state count for RAM cycles (0..15).
REQ-003 SHALL have parameter VGA_WAIT, default 2, wait-state count for VGA RAM cycles (0..15).
REQ-004 SHALL have port clock, input, 1, single system clock; all state changes on its rising edge.
REQ-005 SHALL have port n_reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rom_cs, input, 1, ROM select from address decoder.
REQ-007 SHALL have port ram_cs, input, 1, RAM select from address decoder.
REQ-008 SHALL have port vgaRam_cs, input, 1, VGA RAM select from address decoder.
REQ-009 SHALL have port memwrite, input, 1, CPU memory write in progress.
REQ-010 SHALL have port rom_dout, ram_dout, vga_dout, input, 8 each, read data from the three memories.
REQ-011 SHALL have port cpu_wait_n, output, 1, active-low CPU WAIT request.
REQ-012 SHALL have port rom_en, ram_en, vga_en, output, 1 each, one-cycle memory enable strobes.
REQ-013 SHALL have port ram_we, vga_we, output, 1 each, one-cycle write strobes.
REQ-014 SHALL have port data_out, output, 8, latched read data to CPU data-in mux.
REQ-015 SHALL have port data_valid, output, 1, data_out holds data from the current read cycle.

Function
REQ-016 SHALL select target region by priority rom_cs > vgaRam_cs > ram_cs; lower selects are ignored while a higher one is asserted.
REQ-017 SHALL implement states IDLE, WAIT, ACCESS, CAPTURE, HOLD.
REQ-018 IDLE: on any select asserted, SHALL latch region and direction (write if memwrite=1, else read), load wait counter with the region's WAIT value, drive cpu_wait_n=0, go to WAIT if value>0 else ACCESS.
REQ-019 WAIT: SHALL decrement counter each cycle; go to ACCESS the cycle after counter reaches 1.
REQ-020 ACCESS: SHALL assert exactly one region enable for one cycle; for writes also the matching *_we (no rom write strobe; ROM writes enable nothing).
REQ-021 CAPTURE: on reads SHALL register selected *_dout into data_out and set data_valid=1; on writes SHALL leave data_out unchanged.
REQ-022 SHALL drive cpu_wait_n=1 from entry into HOLD; held low in WAIT, ACCESS, CAPTURE.
REQ-023 HOLD: SHALL remain until all three selects are low, then go to IDLE and clear data_valid.
REQ-024 Zero-wait read latency: select seen in cycle 0, enable in cycle 1, data_out valid and cpu_wait_n=1 in cycle 3.
REQ-025 If all selects drop while in WAIT, SHALL return to IDLE with no strobe issued and cpu_wait_n=1.
REQ-026 Select changes after IDLE latch SHALL NOT alter region or direction of the cycle in progress.
REQ-027 memwrite and read-only select both active SHALL be treated as write.
REQ-028 Wait counter SHALL be 4 bits; parameter values above 15 are a configuration error.

Reset
REQ-029 n_reset low SHALL immediately force IDLE, cpu_wait_n=1, all enables/write strobes 0, data_out=8'h00, data_valid=0, counter=0, regardless of state.
REQ-030 After n_reset release, a select already asserted SHALL start a cycle on the first clock edge.

Structure
REQ-031 State encoding and region codes (NONE, ROM, RAM, VGA) SHALL live in a shared package with the system's memory-map constants.
REQ-032 SHALL be a single module; a wait-state down-counter may be a sub-module named wait_counter.

Verification
REQ-033 ram_cs read, RAM_WAIT=0, ram_dout=8'hA5 -> ram_en pulse cycle 1, data_out=8'hA5, data_valid=1, cpu_wait_n=1 at cycle 3.
REQ-034 rom_cs read, ROM_WAIT=1 -> cpu_wait_n low 3 cycles, rom_en at cycle 2, data from rom_dout.
REQ-035 vgaRam_cs and ram_cs both high, memwrite=1, VGA_WAIT=2 -> vga_en and vga_we single pulse at cycle 3, ram_en/ram_we never asserted.
REQ-036 rom_cs read, ROM_WAIT=3, selects drop in cycle 2 -> no rom_en, IDLE next cycle, cpu_wait_n=1.
REQ-037 n_reset pulsed low during ACCESS -> strobes low immediately, cpu_wait_n=1, data_valid=0; selects held -> new cycle after release.
REQ-038 Back-to-back RAM reads with selects low for one cycle between -> two independent cycles, data_valid cleared between.

Source files
------------

// File: rtl/mem_cycle_ctrl_pkg.sv
// Shared types and constants for the memory cycle controller.
package mem_cycle_ctrl_pkg;

    // Width of the wait-state down-counter; wait parameters must fit in it.
    localparam int unsigned WAIT_W = 4;

    // System memory map (Z80-style 64 KiB space).
    localparam logic [15:0] ROM_BASE = 16'h0000;
    localparam logic [15:0] ROM_LAST = 16'h1FFF;
    localparam logic [15:0] RAM_BASE = 16'h2000;
    localparam logic [15:0] RAM_LAST = 16'hDFFF;
    localparam logic [15:0] VGA_BASE = 16'hE000;
    localparam logic [15:0] VGA_LAST = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_CAPTURE,
        ST_HOLD
    } state_t;

    typedef enum logic [1:0] {
        RGN_NONE,
        RGN_ROM,
        RGN_RAM,
        RGN_VGA
    } region_t;

    // Region chosen by fixed priority ROM > VGA > RAM.
    function automatic region_t pick_region(input logic rom_sel,
                                            input logic vga_sel,
                                            input logic ram_sel);
        if (rom_sel)      return RGN_ROM;
        else if (vga_sel) return RGN_VGA;
        else if (ram_sel) return RGN_RAM;
        else              return RGN_NONE;
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable 4-bit wait-state down-counter with clear; flags the final wait cycle.
module wait_counter
    import mem_cycle_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] load_val_i,
    input  logic              dec_i,
    input  logic              clr_i,
    output logic              last_o
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Next count: clear beats load beats decrement; never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == WAIT_W'(1));

endmodule

// File: rtl/mem_cycle_ctrl.sv
// Memory cycle controller: inserts per-region wait states, strobes the
// selected memory once, captures read data and holds CPU WAIT until done.
module mem_cycle_ctrl
    import mem_cycle_ctrl_pkg::*;
#(
    parameter int unsigned ROM_WAIT = 1,
    parameter int unsigned RAM_WAIT = 0,
    parameter int unsigned VGA_WAIT = 2
) (
    input  logic       clock,
    input  logic       n_reset,
    input  logic       rom_cs,
    input  logic       ram_cs,
    input  logic       vgaRam_cs,
    input  logic       memwrite,
    input  logic [7:0] rom_dout,
    input  logic [7:0] ram_dout,
    input  logic [7:0] vga_dout,
    output logic       cpu_wait_n,
    output logic       rom_en,
    output logic       ram_en,
    output logic       vga_en,
    output logic       ram_we,
    output logic       vga_we,
    output logic [7:0] data_out,
    output logic       data_valid
);

    // Wait values are truncated to the counter width; larger values are a
    // configuration error.
    localparam logic [WAIT_W-1:0] ROM_WAIT_C = WAIT_W'(ROM_WAIT);
    localparam logic [WAIT_W-1:0] RAM_WAIT_C = WAIT_W'(RAM_WAIT);
    localparam logic [WAIT_W-1:0] VGA_WAIT_C = WAIT_W'(VGA_WAIT);

    state_t      state_q,  state_d;
    region_t     region_q, region_d;
    logic        write_q,  write_d;
    logic [7:0]  data_q,   data_d;
    logic        valid_q,  valid_d;

    logic              any_cs;
    region_t           sel_region;
    logic [WAIT_W-1:0] sel_wait;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_clr;
    logic              cnt_last;

    assign any_cs     = rom_cs | ram_cs | vgaRam_cs;
    assign sel_region = pick_region(rom_cs, vgaRam_cs, ram_cs);

    // Wait-state count for the region currently being selected.
    always_comb begin
        sel_wait = '0;
        case (sel_region)
            RGN_ROM: sel_wait = ROM_WAIT_C;
            RGN_RAM: sel_wait = RAM_WAIT_C;
            RGN_VGA: sel_wait = VGA_WAIT_C;
            default: sel_wait = '0;
        endcase
    end

    wait_counter u_wait_counter (
        .clk_i      (clock),
        .rst_ni     (n_reset),
        .load_i     (cnt_load),
        .load_val_i (sel_wait),
        .dec_i      (cnt_dec),
        .clr_i      (cnt_clr),
        .last_o     (cnt_last)
    );

    // Next-state, cycle latch and read-data capture.
    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        write_d  = write_q;
        data_d   = data_q;
        valid_d  = valid_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_cs) begin
                    region_d = sel_region;
                    write_d  = memwrite;
                    cnt_load = 1'b1;
                    state_d  = (sel_wait != '0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                // An abandoned cycle leaves without touching any memory.
                if (!any_cs) begin
                    cnt_clr  = 1'b1;
                    region_d = RGN_NONE;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!write_q) begin
                    valid_d = 1'b1;
                    case (region_q)
                        RGN_ROM: data_d = rom_dout;
                        RGN_RAM: data_d = ram_dout;
                        RGN_VGA: data_d = vga_dout;
                        default: data_d = data_q;
                    endcase
                end
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!any_cs) begin
                    valid_d  = 1'b0;
                    region_d = RGN_NONE;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and cycle registers.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= ST_IDLE;
            region_q <= RGN_NONE;
            write_q  <= 1'b0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            write_q  <= write_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    // Strobes and WAIT decoded from registered state only.
    always_comb begin
        cpu_wait_n = 1'b1;
        rom_en     = 1'b0;
        ram_en     = 1'b0;
        vga_en     = 1'b0;
        ram_we     = 1'b0;
        vga_we     = 1'b0;
        case (state_q)
            ST_WAIT, ST_CAPTURE: cpu_wait_n = 1'b0;
            ST_ACCESS: begin
                cpu_wait_n = 1'b0;
                case (region_q)
                    RGN_ROM: rom_en = !write_q;
                    RGN_RAM: begin
                        ram_en = 1'b1;
                        ram_we = write_q;
                    end
                    RGN_VGA: begin
                        vga_en = 1'b1;
                        vga_we = write_q;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_mem_cycle_ctrl.sv
// Scoreboard bench for mem_cycle_ctrl: default-wait instance plus a
// ROM_WAIT=3 instance for the abandoned-cycle case.
module tb_mem_cycle_ctrl;

    logic       clock = 1'b0;
    logic       n_reset;
    logic       rom_cs, ram_cs, vgaRam_cs, memwrite;
    logic [7:0] rom_dout, ram_dout, vga_dout;
    logic       cpu_wait_n, rom_en, ram_en, vga_en, ram_we, vga_we;
    logic [7:0] data_out;
    logic       data_valid;

    logic       rom_cs3, ram_cs3, vga_cs3, memwrite3;
    logic [7:0] rom_dout3, ram_dout3, vga_dout3;
    logic       cpu_wait_n3, rom_en3, ram_en3, vga_en3, ram_we3, vga_we3;
    logic [7:0] data_out3;
    logic       data_valid3;

    typedef struct {
        logic [4:0]  vec;
        int unsigned cyc;
    } strobe_t;

    strobe_t     sq[$];
    logic [7:0]  dq[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned rom3_pulses = 0;
    logic        dv_prev = 1'b0;
    logic [7:0]  last_data = 8'h00;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    mem_cycle_ctrl #(.ROM_WAIT(1), .RAM_WAIT(0), .VGA_WAIT(2)) dut (
        .clock(clock), .n_reset(n_reset),
        .rom_cs(rom_cs), .ram_cs(ram_cs), .vgaRam_cs(vgaRam_cs), .memwrite(memwrite),
        .rom_dout(rom_dout), .ram_dout(ram_dout), .vga_dout(vga_dout),
        .cpu_wait_n(cpu_wait_n), .rom_en(rom_en), .ram_en(ram_en), .vga_en(vga_en),
        .ram_we(ram_we), .vga_we(vga_we), .data_out(data_out), .data_valid(data_valid)
    );

    mem_cycle_ctrl #(.ROM_WAIT(3), .RAM_WAIT(0), .VGA_WAIT(2)) dut3 (
        .clock(clock), .n_reset(n_reset),
        .rom_cs(rom_cs3), .ram_cs(ram_cs3), .vgaRam_cs(vga_cs3), .memwrite(memwrite3),
        .rom_dout(rom_dout3), .ram_dout(ram_dout3), .vga_dout(vga_dout3),
        .cpu_wait_n(cpu_wait_n3), .rom_en(rom_en3), .ram_en(ram_en3), .vga_en(vga_en3),
        .ram_we(ram_we3), .vga_we(vga_we3), .data_out(data_out3), .data_valid(data_valid3)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pop expected strobes and read data as the DUT produces them.
    always @(negedge clock) begin : monitor
        strobe_t    e;
        logic [4:0] s;
        logic [7:0] d;
        s = {rom_en, ram_en, vga_en, ram_we, vga_we};
        if (n_reset && (s != 5'b0)) begin
            if (sq.size() == 0) begin
                check_val("unexpected strobe", 32'(s), 32'h0);
            end else begin
                e = sq.pop_front();
                check_val("strobe vector", 32'(s), 32'(e.vec));
                check_val("strobe cycle", cyc, e.cyc);
            end
        end
        if (n_reset && data_valid && !dv_prev) begin
            if (dq.size() == 0) begin
                check_val("unexpected data_valid", 32'(data_valid), 32'h0);
            end else begin
                d = dq.pop_front();
                check_val("read data", 32'(data_out), 32'(d));
            end
        end
        dv_prev = data_valid;
        if (rom_en3) rom3_pulses++;
    end

    // One complete CPU cycle on the default instance, entered and left on a negedge.
    task automatic run_cycle(input string tag, input logic r, input logic ra, input logic v,
                             input logic we, input int unsigned w, input logic [4:0] vec,
                             input logic rd, input logic [7:0] dexp, input logic perturb);
        rom_cs = r; ram_cs = ra; vgaRam_cs = v; memwrite = we;
        if (vec != 5'b0) sq.push_back('{vec: vec, cyc: cyc + w + 1});
        if (rd) dq.push_back(dexp);
        for (int unsigned k = 1; k <= w + 3; k++) begin
            @(negedge clock);
            check_val({tag, " wait_n"}, 32'(cpu_wait_n), 32'(k == w + 3));
            if (perturb && k == 1) begin
                rom_cs = 1'b1; ram_cs = 1'b1; memwrite = 1'b1;
            end
        end
        check_val({tag, " valid"}, 32'(data_valid), 32'(rd));
        check_val({tag, " data"}, 32'(data_out), 32'(rd ? dexp : last_data));
        if (rd) last_data = dexp;
        rom_cs = 1'b0; ram_cs = 1'b0; vgaRam_cs = 1'b0; memwrite = 1'b0;
        @(negedge clock);
        check_val({tag, " valid clr"}, 32'(data_valid), 32'h0);
        check_val({tag, " idle wait_n"}, 32'(cpu_wait_n), 32'h1);
    endtask

    initial begin
        n_reset = 1'b0;
        rom_cs = 1'b0; ram_cs = 1'b0; vgaRam_cs = 1'b0; memwrite = 1'b0;
        rom_dout = 8'h3C; ram_dout = 8'hA5; vga_dout = 8'h5A;
        rom_cs3 = 1'b0; ram_cs3 = 1'b0; vga_cs3 = 1'b0; memwrite3 = 1'b0;
        rom_dout3 = 8'h00; ram_dout3 = 8'h00; vga_dout3 = 8'h00;

        repeat (2) @(negedge clock);
        check_val("reset wait_n", 32'(cpu_wait_n), 32'h1);
        check_val("reset data_out", 32'(data_out), 32'h0);
        check_val("reset valid", 32'(data_valid), 32'h0);
        check_val("reset strobes", 32'({rom_en, ram_en, vga_en, ram_we, vga_we}), 32'h0);
        n_reset = 1'b1;

        run_cycle("ram rd", 0, 1, 0, 0, 0, 5'b01000, 1, 8'hA5, 0);
        ram_dout = 8'hC3;
        run_cycle("ram rd2", 0, 1, 0, 0, 0, 5'b01000, 1, 8'hC3, 0);
        run_cycle("rom rd", 1, 0, 0, 0, 1, 5'b10000, 1, 8'h3C, 0);
        run_cycle("vga wr", 0, 1, 1, 1, 2, 5'b00101, 0, 8'h00, 0);
        run_cycle("rom prio", 1, 1, 0, 0, 1, 5'b10000, 1, 8'h3C, 0);
        run_cycle("vga rd", 0, 1, 1, 0, 2, 5'b00100, 1, 8'h5A, 0);
        run_cycle("ram wr", 0, 1, 0, 1, 0, 5'b01010, 0, 8'h00, 0);
        run_cycle("rom wr", 1, 0, 0, 1, 1, 5'b00000, 0, 8'h00, 0);
        vga_dout = 8'h96;
        run_cycle("latched", 0, 0, 1, 0, 2, 5'b00100, 1, 8'h96, 1);

        // Reset in the middle of ACCESS with the select held throughout.
        ram_dout = 8'h11;
        ram_cs = 1'b1;
        sq.push_back('{vec: 5'b01000, cyc: cyc + 1});
        @(negedge clock);
        check_val("pre-reset ram_en", 32'(ram_en), 32'h1);
        #2 n_reset = 1'b0;
        #1;
        check_val("rst ram_en", 32'(ram_en), 32'h0);
        check_val("rst wait_n", 32'(cpu_wait_n), 32'h1);
        check_val("rst valid", 32'(data_valid), 32'h0);
        check_val("rst data_out", 32'(data_out), 32'h0);
        last_data = 8'h00;
        @(negedge clock);
        n_reset = 1'b1;
        ram_dout = 8'h77;
        run_cycle("post-rst", 0, 1, 0, 0, 0, 5'b01000, 1, 8'h77, 0);

        // ROM_WAIT=3 instance: selects drop during WAIT.
        rom_dout3 = 8'hE7;
        rom_cs3 = 1'b1;
        @(negedge clock);
        check_val("abort w1 wait_n", 32'(cpu_wait_n3), 32'h0);
        @(negedge clock);
        check_val("abort w2 wait_n", 32'(cpu_wait_n3), 32'h0);
        rom_cs3 = 1'b0;
        @(negedge clock);
        check_val("abort idle wait_n", 32'(cpu_wait_n3), 32'h1);
        @(negedge clock);
        check_val("abort no rom_en", rom3_pulses, 32'h0);
        check_val("abort valid", 32'(data_valid3), 32'h0);

        // Same instance, full ROM read with three wait states.
        rom_cs3 = 1'b1;
        for (int unsigned k = 1; k <= 6; k++) begin
            @(negedge clock);
            check_val("rom3 wait_n", 32'(cpu_wait_n3), 32'(k == 6));
            check_val("rom3 rom_en", 32'(rom_en3), 32'(k == 4));
        end
        check_val("rom3 data", 32'(data_out3), 32'hE7);
        check_val("rom3 valid", 32'(data_valid3), 32'h1);
        check_val("rom3 pulses", rom3_pulses, 32'h1);
        rom_cs3 = 1'b0;
        repeat (2) @(negedge clock);

        check_val("strobe queue drained", 32'(sq.size()), 32'h0);
        check_val("data queue drained", 32'(dq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
